sobel_frame_ctrl: RTL

Frame-level sequencer for the Sobel edge detector. It raster-scans a WIDTH x DEPTH 8-bit greyscale image held in an external pixel memory and issues the nine 3x3-window reads for each interior pixel. It accumulates the X and Y gradients, computes the saturated magnitude, and streams the inverted edge value (255 - SUM) to a downstream writer through a valid/ready handshake. It is the sequential engine that replaces the software-style nested loops of the existing sobel model.

---
 rtl/sobel_frame_ctrl_if.sv | 26 ++
 rtl/sobel_frame_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_ctrl_if.sv
// Handshake bundle between the Sobel frame sequencer, its pixel memory and the edge-pixel writer.
// The slave side is the sequencer; the master side drives start, read data and output ready.
interface sobel_frame_ctrl_if #(
   parameter int AW = 16
);
   logic          start;
   logic          busy;
   logic          done;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic          out_valid;
   logic          out_ready;
   logic [7:0]    out_data;
   logic [AW-1:0] out_addr;

   modport slave (
      input  start, rd_data, out_ready,
      output busy, done, rd_en, rd_addr, out_valid, out_data, out_addr
   );

   modport master (
      output start, rd_data, out_ready,
      input  busy, done, rd_en, rd_addr, out_valid, out_data, out_addr
   );
endinterface

// File: rtl/sobel_frame_ctrl.sv
// Raster-scan Sobel sequencer: 2 cycles per border pixel, 13 per interior pixel (9 reads + drain + magnitude).
// Each edge pixel is held on out_valid until out_ready; no reads are issued while waiting.
module sobel_frame_ctrl #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int AW    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   sobel_frame_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_PIX, S_READ, S_DRAIN, S_MAG, S_OUT, S_DONE
   } state_t;

   localparam logic [AW-1:0] W_A    = AW'(WIDTH);
   localparam logic [AW-1:0] XMAX   = AW'(WIDTH - 1);
   localparam logic [AW-1:0] YMAX   = AW'(DEPTH - 1);
   localparam logic [AW-1:0] CORNER = AW'(WIDTH + 1);

   state_t             state_q;
   logic [AW-1:0]      x_q;
   logic [AW-1:0]      y_q;
   logic [3:0]         k_q;
   logic signed [11:0] sumx_q;
   logic signed [11:0] sumy_q;
   logic               busy_q;
   logic               done_q;
   logic               rd_en_q;
   logic [AW-1:0]      rd_addr_q;
   logic               out_valid_q;
   logic [7:0]         out_data_q;
   logic [AW-1:0]      out_addr_q;

   // Tap k walks the column offset I in the outer position, row offset J inner.
   function automatic logic [1:0] tap_i(input logic [3:0] k);
      case (k)
         4'd0, 4'd1, 4'd2: tap_i = 2'd0;
         4'd3, 4'd4, 4'd5: tap_i = 2'd1;
         default:          tap_i = 2'd2;
      endcase
   endfunction

   function automatic logic [1:0] tap_j(input logic [3:0] k);
      case (k)
         4'd0, 4'd3, 4'd6: tap_j = 2'd0;
         4'd1, 4'd4, 4'd7: tap_j = 2'd1;
         default:          tap_j = 2'd2;
      endcase
   endfunction

   // sgn selects -1/0/+1 from the offset along the gradient axis; the centre of the other axis doubles.
   function automatic logic signed [11:0] tap_term(input logic [1:0] sgn,
                                                   input logic [1:0] dbl,
                                                   input logic [7:0] pix);
      logic signed [11:0] p;
      p = (dbl == 2'd1) ? $signed({3'd0, pix, 1'b0}) : $signed({4'd0, pix});
      case (sgn)
         2'd0:    tap_term = -p;
         2'd1:    tap_term = '0;
         default: tap_term = p;
      endcase
   endfunction

   logic [3:0]         nxt_k;
   logic [3:0]         acc_k;
   logic [AW-1:0]      tap_addr;
   logic signed [11:0] term_x;
   logic signed [11:0] term_y;
   logic [11:0]        abs_x;
   logic [11:0]        abs_y;
   logic [11:0]        mag_sum;
   logic [7:0]         edge_val;
   logic               border;
   logic               last_px;

   assign nxt_k    = (state_q == S_PIX) ? 4'd0 : k_q + 4'd1;
   assign acc_k    = (state_q == S_DRAIN) ? k_q : k_q - 4'd1;
   // out_addr_q tracks X + Y*WIDTH, so the tap address is an offset from it.
   assign tap_addr = out_addr_q
                   + {{(AW-2){1'b0}}, tap_i(nxt_k)}
                   + {{(AW-2){1'b0}}, tap_j(nxt_k)} * W_A
                   - CORNER;

   assign term_x   = tap_term(tap_i(acc_k), tap_j(acc_k), bus.rd_data);
   assign term_y   = tap_term(tap_j(acc_k), tap_i(acc_k), bus.rd_data);
   assign abs_x    = sumx_q[11] ? -sumx_q : sumx_q;
   assign abs_y    = sumy_q[11] ? -sumy_q : sumy_q;
   assign mag_sum  = abs_x + abs_y;
   assign edge_val = (mag_sum > 12'd255) ? 8'd0 : 8'd255 - mag_sum[7:0];

   assign border   = (x_q == '0) || (y_q == '0) || (x_q == XMAX) || (y_q == YMAX);
   assign last_px  = (x_q == XMAX) && (y_q == YMAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         k_q         <= '0;
         sumx_q      <= '0;
         sumy_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rd_en_q     <= 1'b0;
         rd_addr_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  x_q        <= '0;
                  y_q        <= '0;
                  out_addr_q <= '0;
                  busy_q     <= 1'b1;
                  state_q    <= S_PIX;
               end
            end
            S_PIX: begin
               if (border) begin
                  out_data_q  <= 8'd255;
                  out_valid_q <= 1'b1;
                  state_q     <= S_OUT;
               end else begin
                  sumx_q    <= '0;
                  sumy_q    <= '0;
                  k_q       <= 4'd0;
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= tap_addr;
                  state_q   <= S_READ;
               end
            end
            S_READ: begin
               if (k_q != 4'd0) begin
                  sumx_q <= sumx_q + term_x;
                  sumy_q <= sumy_q + term_y;
               end
               if (k_q == 4'd8) begin
                  rd_en_q <= 1'b0;
                  state_q <= S_DRAIN;
               end else begin
                  k_q       <= nxt_k;
                  rd_addr_q <= tap_addr;
               end
            end
            S_DRAIN: begin
               sumx_q  <= sumx_q + term_x;
               sumy_q  <= sumy_q + term_y;
               state_q <= S_MAG;
            end
            S_MAG: begin
               out_data_q  <= edge_val;
               out_valid_q <= 1'b1;
               state_q     <= S_OUT;
            end
            S_OUT: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  if (x_q == XMAX) begin
                     x_q <= '0;
                     y_q <= y_q + 1'b1;
                  end else begin
                     x_q <= x_q + 1'b1;
                  end
                  if (last_px) begin
                     out_addr_q <= '0;
                     done_q     <= 1'b1;
                     busy_q     <= 1'b0;
                     state_q    <= S_DONE;
                  end else begin
                     out_addr_q <= out_addr_q + 1'b1;
                     state_q    <= S_PIX;
                  end
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.rd_en     = rd_en_q;
   assign bus.rd_addr   = rd_addr_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_addr  = out_addr_q;

endmodule
